// File: rtl/ma_decimator.sv
// Sample decimator feeding a small output FIFO: keeps every DECIM-th strobed
// sample and queues it for a ready/valid downstream, flagging dropped samples.
module ma_decimator #(
    parameter int WL    = 32,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic signed [WL-1:0]         data_in,
    output logic signed [WL-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         overflow
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW   = $clog2(DEPTH + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(DEPTH);

    logic [PH_W-1:0]     phase;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic signed [WL-1:0] mem [DEPTH];

    logic keep;
    logic pop;
    logic full;
    logic push;

    // With DECIM=1 the phase stays at 0 == PH_LAST, so every strobe is kept.
    assign keep = EN && (phase == PH_LAST);
    assign pop  = out_valid && out_ready;
    assign full = (fill == FILL_FULL);
    assign push = keep && (!full || pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase <= '0;
        end else if (EN) begin
            phase <= keep ? '0 : phase + PH_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill <= fill + FW'(1);
            end else if (pop && !push) begin
                fill <= fill - FW'(1);
            end
            if (keep && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is data only; validity is carried entirely by the pointers and fill.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = (fill != '0);

endmodule

// File: tb/tb_ma_decimator.sv
// Bench for ma_decimator: a DECIM=4 and a DECIM=1 instance share stimulus and
// are each checked every cycle against a queue-based model.
module tb_ma_decimator;

    logic               CLK;
    logic               RST;
    logic               EN;
    logic signed [31:0] data_in;
    logic               out_ready;

    logic signed [31:0] od [2];
    logic               ov [2];
    logic [2:0]         fl [2];
    logic               of [2];

    int checks = 0;
    int errors = 0;

    ma_decimator #(.WL(32), .DECIM(4), .DEPTH(4)) u_d4 (
        .CLK(CLK), .RST(RST), .EN(EN), .data_in(data_in),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .fill(fl[0]), .overflow(of[0])
    );

    ma_decimator #(.WL(32), .DECIM(1), .DEPTH(4)) u_d1 (
        .CLK(CLK), .RST(RST), .EN(EN), .data_in(data_in),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .fill(fl[1]), .overflow(of[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: count strobes since reset, keep every DEC-th, queue with capacity 4.
    for (genvar k = 0; k < 2; k++) begin : g_chk
        localparam int DEC = (k == 0) ? 4 : 1;
        logic signed [31:0] q [$];
        int  en_cnt = 0;
        bit  ovf = 0;
        bit  pop, full, keep;

        always @(posedge CLK) begin
            if (RST) begin
                q.delete();
                en_cnt = 0;
                ovf = 0;
            end else begin
                pop  = (q.size() != 0) && out_ready;
                full = (q.size() == 4);
                keep = EN && ((en_cnt % DEC) == DEC - 1);
                if (EN) en_cnt++;
                if (pop) void'(q.pop_front());
                if (keep) begin
                    if (!full || pop) q.push_back(data_in);
                    else ovf = 1;
                end
            end
            #1;
            check($sformatf("d%0d.out_valid", k), 32'(ov[k]), 32'(q.size() != 0));
            check($sformatf("d%0d.fill", k), 32'(fl[k]), 32'(q.size()));
            check($sformatf("d%0d.overflow", k), 32'(of[k]), 32'(ovf));
            if (q.size() != 0)
                check($sformatf("d%0d.out_data", k), od[k], q[0]);
        end
    end

    task automatic step(input bit en, input logic [31:0] d, input bit rdy);
        @(negedge CLK);
        EN = en;
        data_in = d;
        out_ready = rdy;
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        EN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    int bias;

    initial begin
        RST = 1'b1;
        EN = 1'b0;
        data_in = '0;
        out_ready = 1'b0;
        #1;
        check("reset.valid4", 32'(ov[0]), 0);
        check("reset.fill4", 32'(fl[0]), 0);
        check("reset.ovf1", 32'(of[1]), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Decimation by 4 with a ready downstream.
        for (int i = 2; i <= 9; i++) begin
            step(1'b1, 32'(i), 1'b1);
            if (i == 5) check("dec.first", od[0], 32'd5);
            if (i == 6) check("dec.gone", 32'(ov[0]), 0);
            if (i == 9) check("dec.second", od[0], 32'd9);
        end
        check("dec.ovf", 32'(of[0]), 0);

        // Strobe gaps hold the phase.
        do_reset();
        step(1'b1, 32'd10, 1'b1);
        step(1'b0, 32'd99, 1'b1);
        step(1'b1, 32'd11, 1'b1);
        step(1'b1, 32'd12, 1'b1);
        check("gap.none", 32'(ov[0]), 0);
        step(1'b0, 32'd98, 1'b1);
        step(1'b1, 32'd13, 1'b1);
        check("gap.valid", 32'(ov[0]), 1);
        check("gap.data", od[0], 32'd13);

        // Overflow then drain on the DECIM=1 instance.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0);
        check("ovf.fill", 32'(fl[1]), 4);
        check("ovf.flag", 32'(of[1]), 1);
        check("ovf.head", od[1], 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 32'd0, 1'b1);
            check("drain.fill", 32'(fl[1]), 32'(4 - i));
            if (i < 4) check("drain.head", od[1], 32'(i + 1));
        end
        check("drain.ovf", 32'(of[1]), 1);

        // Push into a full FIFO alongside a pop.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0);
        step(1'b1, 32'd5, 1'b1);
        check("fullpop.fill", 32'(fl[1]), 4);
        check("fullpop.ovf", 32'(of[1]), 0);
        check("fullpop.head", od[1], 32'd2);

        // Bit-exact signed extremes.
        do_reset();
        step(1'b1, -32'sd7, 1'b1);
        check("signed.neg", od[1], 32'hFFFF_FFF9);
        step(1'b1, 32'h7FFF_FFFF, 1'b1);
        check("signed.max", od[1], 32'h7FFF_FFFF);

        // Asynchronous reset with fill=3, phase=2 on the DECIM=4 instance.
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 32'(100 + i), 1'b0);
        check("arst.pre_fill", 32'(fl[0]), 3);
        check("arst.pre_ovf1", 32'(of[1]), 1);
        RST = 1'b1;
        #1;
        check("arst.fill", 32'(fl[0]), 0);
        check("arst.valid", 32'(ov[0]), 0);
        check("arst.ovf1", 32'(of[1]), 0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(200 + i), 1'b1);
            if (i < 3) check("arst.wait", 32'(ov[0]), 0);
            else       check("arst.kept", od[0], 32'd203);
        end

        // Randomized traffic with varying downstream backpressure.
        bias = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) bias = $urandom_range(0, 8);
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) < bias);
        end

        repeat (2) @(posedge CLK);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ma_decimator.md
MA_DECIMATOR -- requirements
Module: ma_decimator

Interface
REQ-001 Parameter: WL, default 32, signed sample word length of data_in and out_data.
REQ-002 Parameter: DECIM, default 4, decimation ratio; legal range 1..256.
REQ-003 Parameter: DEPTH, default 4, output FIFO entries; power of two, 2..64.
REQ-004 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: RST  input  1  asynchronous, active-high reset.
REQ-006 Port: EN  input  1  upstream sample strobe; data_in is valid in every cycle where EN=1.
REQ-007 Port: data_in  input  WL signed  filtered sample from the upstream moving-average stage.
REQ-008 Port: out_data  output  WL signed  FIFO head sample.
REQ-009 Port: out_valid  output  1  high while the FIFO holds at least one sample.
REQ-010 Port: out_ready  input  1  downstream accept; a pop occurs when out_valid=1 and out_ready=1.
REQ-011 Port: fill  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-012 Port: overflow  output  1  sticky flag: a kept sample was dropped.

Function
REQ-013 Phase counter, range 0..DECIM-1: increments on each EN=1 cycle; holds when EN=0.
REQ-014 Sample keep rule: with EN=1 and phase=DECIM-1, data_in is a kept sample and phase wraps to 0.
REQ-015 DECIM=1: every EN=1 sample is a kept sample.
REQ-016 Push condition: push the kept sample when fill<DEPTH, or when a pop occurs in the same cycle.
REQ-017 Full drop: a kept sample arriving with fill=DEPTH and no pop in that cycle is discarded and sets overflow=1.
REQ-018 overflow stays set until RST.
REQ-019 FIFO order: strict first-in-first-out; write and read pointers wrap modulo DEPTH.
REQ-020 fill updates per cycle as follows:
- push only: +1
- pop only: -1
- push and pop together: unchanged
REQ-021 out_valid = (fill != 0).
REQ-022 out_data: equals the head entry whenever out_valid=1; value is don't-care when out_valid=0.
REQ-023 Latency: a sample kept at rising edge k into an empty FIFO gives out_valid=1 and out_data=that sample after edge k.
REQ-024 Pop on empty: out_ready=1 with out_valid=0 has no effect.
REQ-025 Stall: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-026 No arithmetic on data: samples pass bit-exact; no sign extension or truncation.

Reset
REQ-027 While RST=1, regardless of CLK, clear phase, the pointers, fill and overflow to 0; out_valid=0.
REQ-028 RST asserted mid-operation discards all FIFO contents and any partially counted decimation group.
REQ-029 After RST deasserts, the first EN=1 cycle counts as phase 0.

Verification
REQ-030 Decimation: DECIM=4, out_ready=1, reset, then EN=1 with data_in 2,3,4,5,6,7,8,9 on consecutive cycles -> out_data 5 and 9, each shown for one cycle with out_valid=1, one cycle after the sample's edge; overflow=0.
REQ-031 EN gaps: DECIM=4, EN pattern 1,0,1,1,0,1 with data 10,x,11,12,x,13 -> only 13 emitted; phase held during EN=0 cycles.
REQ-032 Overflow and drain: DECIM=1, DEPTH=4, out_ready=0, samples 1..5 -> fill=4, overflow=1; then out_ready=1 -> out_data 1,2,3,4 over 4 cycles, fill returns to 0, overflow stays 1.
REQ-033 Full with pop: DECIM=1, FIFO full holding 1..4, out_ready=1 and EN=1 with data 5 in the same cycle -> 1 popped, 5 pushed, fill stays 4, overflow stays 0.
REQ-034 Signed pass-through: DECIM=1, data_in -7 then 32'h7FFFFFFF -> out_data -7 then 32'h7FFFFFFF, bit-exact.
REQ-035 Async reset: with fill=3 and phase=2, assert RST between clock edges -> fill=0, out_valid=0, overflow=0 immediately, without waiting for a clock edge; the next kept sample is the DECIM-th EN cycle after release.
